// File: rtl/apb_pkg.sv
// Shared types and APB address map for the LSU-to-APB bridge and its peripherals.
// Combinational definitions only: no latency and no backpressure.
package apb_pkg;

  typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_e;

  localparam int TOCNT_W = 8;

  localparam logic [31:0] TIMER_BASE      = 32'h0000_0000;
  localparam logic [31:0] TIMER_CTRL_ADDR = 32'h0000_0004;
  localparam logic [31:0] LED_REG_ADDR    = 32'h0000_0010;
  localparam logic [31:0] SWITCH_REG_ADDR = 32'h0000_0020;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating ACCESS-wait counter; hit_o fires combinationally on the wait cycle that reaches LIMIT.
// No backpressure; LIMIT of 0 disables hit_o. The count never wraps.
module apb_timeout_cnt
  import apb_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam logic [TOCNT_W-1:0] LIMIT_V = TOCNT_W'(LIMIT);

  logic [TOCNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // Compare the post-increment value, so LIMIT stalled ACCESS cycles end the transfer.
  assign hit_o = en_i && (LIMIT != 0) && (cnt_inc == LIMIT_V);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 requester: the response pulse arrives 3 cycles after accept when PREADY is high.
// Backpressure: o_req_ready is high only in IDLE; slave waits stretch ACCESS until PREADY or timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              cnt_clr, cnt_en, cnt_hit;

  apb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk_i (PCLK),
    .rst_i (PRESET),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .hit_o (cnt_hit)
  );

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    unique case (state_q)
      APB_IDLE: begin
        if (i_req_valid) begin
          paddr_d  = i_req_addr;
          pwrite_d = i_req_write;
          pwdata_d = i_req_wdata;
          psel_d   = 1'b1;
          state_d  = APB_SETUP;
        end
      end
      APB_SETUP: begin
        penable_d = 1'b1;
        cnt_clr   = 1'b1;
        state_d   = APB_ACCESS;
      end
      APB_ACCESS: begin
        if (PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
          rsp_err_d   = PSLVERR;
          state_d     = APB_IDLE;
        end else begin
          cnt_en = 1'b1;
          if (cnt_hit) begin
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            state_d     = APB_IDLE;
          end
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = APB_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= APB_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Ready depends on registered state only, never on APB inputs.
  assign o_req_ready = (state_q == APB_IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: randomized APB slave waits/errors checked against a transfer-level timing model.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int T     = 4;
  localparam int BOUND = 20;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        i_req_valid, i_req_write;
  logic [31:0] i_req_addr, i_req_wdata;
  logic        o_req_ready, o_rsp_valid, o_rsp_err;
  logic [31:0] o_rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  int checks = 0;
  int failures = 0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(T)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_write(i_req_write),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Transfer-level reference: w = ACCESS cycles with PREADY low before the ready cycle.
  function automatic int m_lat(input int w);
    return (w < T) ? 3 + w : 2 + T;
  endfunction
  function automatic logic m_err(input int w, input logic slv);
    return (w < T) ? slv : 1'b1;
  endfunction
  function automatic logic [31:0] m_rd(input int w, input logic wr, input logic [31:0] prd, input logic slv);
    return (w < T && !wr && !slv) ? prd : 32'h0;
  endfunction

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Acts as requester and slave for one transfer, recording what the DUT did.
  task automatic drive_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input int w, input logic [31:0] prd, input logic slv,
                            output int lat, output logic [31:0] rd, output logic er,
                            output logic stable, output logic rdy_acc, output logic idle_ok);
    rdy_acc = o_req_ready;
    i_req_valid = 1'b1; i_req_write = wr; i_req_addr = addr; i_req_wdata = wdata;
    PREADY = 1'b0;
    lat = -1; rd = 32'h0; er = 1'b0; stable = 1'b1; idle_ok = 1'b0;
    tick();
    i_req_valid = 1'b0; i_req_write = ~wr; i_req_addr = $urandom(); i_req_wdata = $urandom();
    for (int cyc = 1; cyc <= BOUND; cyc++) begin
      if (o_rsp_valid === 1'b1) begin
        lat = cyc; rd = o_rsp_rdata; er = o_rsp_err;
        idle_ok = (PSEL === 1'b0 && PENABLE === 1'b0 && o_req_ready === 1'b1 &&
                   PADDR === addr && PWDATA === wdata && PWRITE === wr);
        break;
      end
      if (PSEL !== 1'b1 || PENABLE !== logic'(cyc >= 2) || o_req_ready !== 1'b0 ||
          PADDR !== addr || PWDATA !== wdata || PWRITE !== wr)
        stable = 1'b0;
      if (cyc >= 2 && cyc - 2 == w) begin
        PREADY = 1'b1; PRDATA = prd; PSLVERR = slv;
      end else begin
        PREADY = 1'b0; PRDATA = $urandom(); PSLVERR = 1'($urandom_range(0, 1));
      end
      tick();
    end
    PREADY = 1'b0; PSLVERR = 1'b0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1; i_req_valid = 1'b1; PREADY = 1'b1; PSLVERR = 1'b1;
    tick(); tick();
    checks++; if (o_req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_req_ready); end
    checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || PWRITE !== 1'b0) begin failures++; $display("FAIL reset_ctrl got=%b%b%b exp=000", PSEL, PENABLE, PWRITE); end
    checks++; if (PADDR !== 32'h0 || PWDATA !== 32'h0) begin failures++; $display("FAIL reset_bus got=%h/%h exp=0/0", PADDR, PWDATA); end
    checks++; if (o_rsp_valid !== 1'b0 || o_rsp_err !== 1'b0 || o_rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp got=%b/%b/%h exp=0/0/0", o_rsp_valid, o_rsp_err, o_rsp_rdata); end
    PRESET = 1'b0; i_req_valid = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
    tick();
  endtask

  task automatic test_read_basic();
    int lat; logic [31:0] rd; logic er, st, ra, io;
    drive_xfer(1'b0, SWITCH_REG_ADDR, 32'h0, 0, 32'hA5A5_0F0F, 1'b0, lat, rd, er, st, ra, io);
    checks++; if (ra !== 1'b1) begin failures++; $display("FAIL rd_accept_ready got=%b exp=1", ra); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL rd_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 32'hA5A5_0F0F || er !== 1'b0) begin failures++; $display("FAIL rd_data got=%h/%b exp=a5a50f0f/0", rd, er); end
    checks++; if (st !== 1'b1 || io !== 1'b1) begin failures++; $display("FAIL rd_phases got=%b/%b exp=1/1", st, io); end
    tick();
    checks++; if (o_rsp_valid !== 1'b0 || o_rsp_rdata !== 32'hA5A5_0F0F || PADDR !== SWITCH_REG_ADDR) begin
      failures++; $display("FAIL rd_hold got=%b/%h/%h exp=0/a5a50f0f/%h", o_rsp_valid, o_rsp_rdata, PADDR, SWITCH_REG_ADDR); end
  endtask

  task automatic test_write_wait();
    int lat; logic [31:0] rd; logic er, st, ra, io;
    drive_xfer(1'b1, TIMER_CTRL_ADDR, 32'h0000_1234, 3, 32'hDEAD_BEEF, 1'b0, lat, rd, er, st, ra, io);
    checks++; if (lat !== m_lat(3)) begin failures++; $display("FAIL wr_latency got=%0d exp=%0d", lat, m_lat(3)); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL wr_rsp got=%h/%b exp=0/0", rd, er); end
    checks++; if (st !== 1'b1 || io !== 1'b1) begin failures++; $display("FAIL wr_stable got=%b/%b exp=1/1", st, io); end
  endtask

  task automatic test_slverr_b2b();
    int lat; logic [31:0] rd; logic er, st, ra, io;
    drive_xfer(1'b0, LED_REG_ADDR, 32'h0, 1, 32'h1111_2222, 1'b1, lat, rd, er, st, ra, io);
    checks++; if (lat !== m_lat(1) || er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL slverr_rsp got=%0d/%b/%h exp=%0d/1/0", lat, er, rd, m_lat(1)); end
    drive_xfer(1'b0, SWITCH_REG_ADDR, 32'h0, 0, 32'h3333_4444, 1'b0, lat, rd, er, st, ra, io);
    checks++; if (ra !== 1'b1) begin failures++; $display("FAIL slverr_next_accept got=%b exp=1", ra); end
    checks++; if (lat !== 3 || rd !== 32'h3333_4444 || er !== 1'b0) begin failures++; $display("FAIL slverr_next_rsp got=%0d/%h/%b exp=3/33334444/0", lat, rd, er); end
  endtask

  task automatic test_timeout();
    int lat; logic [31:0] rd; logic er, st, ra, io;
    drive_xfer(1'b0, TIMER_BASE, 32'h0, 50, 32'h5555_6666, 1'b0, lat, rd, er, st, ra, io);
    checks++; if (lat !== 2 + T) begin failures++; $display("FAIL timeout_latency got=%0d exp=%0d", lat, 2 + T); end
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL timeout_rsp got=%b/%h exp=1/0", er, rd); end
    checks++; if (st !== 1'b1 || io !== 1'b1) begin failures++; $display("FAIL timeout_psel got=%b/%b exp=1/1", st, io); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd, prd; logic er, st, ra, io;
    for (int i = 0; i < 4; i++) begin
      prd = $urandom();
      drive_xfer(1'b0, SWITCH_REG_ADDR + 32'(4 * i), 32'h0, 0, prd, 1'b0, lat, rd, er, st, ra, io);
      checks++; if (ra !== 1'b1 || lat !== 3 || st !== 1'b1) begin failures++; $display("FAIL b2b_timing[%0d] got=%b/%0d/%b exp=1/3/1", i, ra, lat, st); end
      checks++; if (rd !== prd || er !== 1'b0) begin failures++; $display("FAIL b2b_data[%0d] got=%h/%b exp=%h/0", i, rd, er, prd); end
    end
  endtask

  task automatic test_random();
    int lat, w; logic [31:0] rd, prd, addr, wd; logic er, st, ra, io, wr, slv;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1)); slv = ($urandom_range(0, 3) == 0);
      w = $urandom_range(0, 6); addr = $urandom(); wd = $urandom(); prd = $urandom();
      drive_xfer(wr, addr, wd, w, prd, slv, lat, rd, er, st, ra, io);
      checks++; if (ra !== 1'b1 || lat !== m_lat(w) || st !== 1'b1 || io !== 1'b1) begin
        failures++; $display("FAIL rand_timing[%0d] w=%0d got=%b/%0d/%b/%b exp=1/%0d/1/1", i, w, ra, lat, st, io, m_lat(w)); end
      checks++; if (rd !== m_rd(w, wr, prd, slv) || er !== m_err(w, slv)) begin
        failures++; $display("FAIL rand_rsp[%0d] got=%h/%b exp=%h/%b", i, rd, er, m_rd(w, wr, prd, slv), m_err(w, slv)); end
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er, st, ra, io, seen;
    i_req_valid = 1'b1; i_req_write = 1'b1; i_req_addr = 32'hCAFE_0010; i_req_wdata = 32'h1357_9BDF;
    PREADY = 1'b0;
    tick(); i_req_valid = 1'b0;
    tick();
    checks++; if (PENABLE !== 1'b1 || PSEL !== 1'b1) begin failures++; $display("FAIL rstmid_access got=%b%b exp=11", PSEL, PENABLE); end
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || PWRITE !== 1'b0 || PADDR !== 32'h0 || PWDATA !== 32'h0) begin
      failures++; $display("FAIL rstmid_bus got=%b%b%b/%h/%h exp=000/0/0", PSEL, PENABLE, PWRITE, PADDR, PWDATA); end
    checks++; if (o_rsp_valid !== 1'b0 || o_rsp_rdata !== 32'h0 || o_rsp_err !== 1'b0 || o_req_ready !== 1'b1) begin
      failures++; $display("FAIL rstmid_rsp got=%b/%h/%b/%b exp=0/0/0/1", o_rsp_valid, o_rsp_rdata, o_rsp_err, o_req_ready); end
    PREADY = 1'b1; seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (o_rsp_valid !== 1'b0 || PSEL !== 1'b0) seen = 1'b1;
    end
    PREADY = 1'b0;
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_no_rsp got=%b exp=0", seen); end
    drive_xfer(1'b0, SWITCH_REG_ADDR, 32'h0, 2, 32'h0BAD_F00D, 1'b0, lat, rd, er, st, ra, io);
    checks++; if (lat !== m_lat(2) || rd !== 32'h0BAD_F00D || er !== 1'b0) begin
      failures++; $display("FAIL rstmid_recover got=%0d/%h/%b exp=%0d/0badf00d/0", lat, rd, er, m_lat(2)); end
  endtask

  initial begin
    PRESET = 1'b1; i_req_valid = 1'b0; i_req_write = 1'b0; i_req_addr = 32'h0; i_req_wdata = 32'h0;
    PRDATA = 32'h0; PREADY = 1'b0; PSLVERR = 1'b0;
    test_reset();
    test_read_basic();
    test_write_wait();
    test_slverr_b2b();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
